// File: rtl/clkgen_pkg.sv
// Shared constants and config types for the multi-channel clock generator.
// Config fields are held at a fixed maximum width; channels zero-extend into them.
package clkgen_pkg;

   localparam int unsigned W_DEF     = 28;
   localparam int unsigned DEF_DIV_C = 50000000;
   localparam int unsigned DEF_HI_C  = 25000000;
   localparam int unsigned CFG_W_MAX = 32;

   typedef struct packed {
      logic [CFG_W_MAX-1:0] div;
      logic [CFG_W_MAX-1:0] hi;
   } ch_cfg_t;

   function automatic ch_cfg_t cfg_pack(logic [CFG_W_MAX-1:0] div, logic [CFG_W_MAX-1:0] hi);
      ch_cfg_t c;
      c.div = div;
      c.hi  = hi;
      return c;
   endfunction

endpackage

// File: rtl/clkgen_ch.sv
// One divided-clock channel: counter, double-buffered period/high-time config and
// registered clkout/tick outputs. Config changes only take effect at period boundaries.
module clkgen_ch
   import clkgen_pkg::*;
#(
   parameter int unsigned W       = W_DEF,
   parameter int unsigned DEF_DIV = DEF_DIV_C,
   parameter int unsigned DEF_HI  = DEF_HI_C
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   input  logic         sync_i,
   input  logic         we_i,
   input  logic [W-1:0] div_i,
   input  logic [W-1:0] hi_i,
   output logic         clkout_o,
   output logic         tick_o,
   output logic         pend_o
);

   localparam logic [W-1:0] DefDivW = W'(DEF_DIV);
   localparam logic [W-1:0] DefHiW  = W'(DEF_HI);
   localparam ch_cfg_t      CfgRst  = '{div: CFG_W_MAX'(DefDivW), hi: CFG_W_MAX'(DefHiW)};
   localparam logic [CFG_W_MAX-1:0] One = CFG_W_MAX'(1);

   ch_cfg_t        act_q, act_d;
   ch_cfg_t        shd_q, shd_d;
   logic           pend_q, pend_d;
   logic           en_q, en_d;
   logic [W-1:0]   cnt_q, cnt_d;
   logic           clkout_q, clkout_d;
   logic           tick_q, tick_d;

   logic                 idle, wrap, apply, live;
   logic [CFG_W_MAX-1:0] cnt_ext, cnt_nxt_ext;

   always_comb begin
      en_d   = en_i;
      act_d  = act_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      cnt_d  = cnt_q;

      cnt_ext = CFG_W_MAX'(cnt_q);
      idle    = !en_q || (act_q.div == '0);
      // div-1 is only evaluated for a running channel, so div==0 never underflows
      wrap    = !idle && (cnt_ext == act_q.div - One);
      apply   = idle || sync_i || wrap;

      if (apply) begin
         cnt_d = '0;
         if (pend_q) begin
            act_d = shd_q;
         end
         pend_d = 1'b0;
      end else begin
         cnt_d = cnt_q + W'(1);
      end

      // A write on the apply edge lands in the shadow and stays pending
      if (we_i) begin
         shd_d  = cfg_pack(CFG_W_MAX'(div_i), CFG_W_MAX'(hi_i));
         pend_d = 1'b1;
      end

      if (!en_i) begin
         cnt_d = '0;
      end

      cnt_nxt_ext = CFG_W_MAX'(cnt_d);
      live        = en_i && (act_d.div != '0);
      clkout_d    = live && (cnt_nxt_ext < act_d.hi);
      tick_d      = live && (cnt_nxt_ext == act_d.div - One);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         act_q    <= CfgRst;
         shd_q    <= CfgRst;
         pend_q   <= 1'b0;
         en_q     <= 1'b0;
         cnt_q    <= '0;
         clkout_q <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         act_q    <= act_d;
         shd_q    <= shd_d;
         pend_q   <= pend_d;
         en_q     <= en_d;
         cnt_q    <= cnt_d;
         clkout_q <= clkout_d;
         tick_q   <= tick_d;
      end
   end

   assign clkout_o = clkout_q;
   assign tick_o   = tick_q;
   assign pend_o   = pend_q;

endmodule

// File: rtl/clkgen_multi.sv
// NCH independent programmable clock dividers sharing one input clock.
// Decodes the config address into per-channel write strobes and fans out sync_start.
module clkgen_multi
   import clkgen_pkg::*;
#(
   parameter int unsigned NCH     = 4,
   parameter int unsigned W       = W_DEF,
   parameter int unsigned DEF_DIV = DEF_DIV_C,
   parameter int unsigned DEF_HI  = DEF_HI_C,
   localparam int unsigned SelW   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic            clkin,
   input  logic            rst_n,
   input  logic [NCH-1:0]  ch_en,
   input  logic            sync_start,
   input  logic            cfg_we,
   input  logic [SelW-1:0] cfg_sel,
   input  logic [W-1:0]    cfg_div,
   input  logic [W-1:0]    cfg_hi,
   output logic [NCH-1:0]  clkout,
   output logic [NCH-1:0]  tick,
   output logic [NCH-1:0]  cfg_pend
);

   logic [NCH-1:0] ch_we;

   // Addresses at or above NCH match no channel and are dropped
   always_comb begin
      ch_we = '0;
      for (int i = 0; i < NCH; i++) begin
         ch_we[i] = cfg_we && (int'(cfg_sel) == i);
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : gen_ch
      clkgen_ch #(
         .W       (W),
         .DEF_DIV (DEF_DIV),
         .DEF_HI  (DEF_HI)
      ) u_ch (
         .clk_i    (clkin),
         .rst_ni   (rst_n),
         .en_i     (ch_en[g]),
         .sync_i   (sync_start),
         .we_i     (ch_we[g]),
         .div_i    (cfg_div),
         .hi_i     (cfg_hi),
         .clkout_o (clkout[g]),
         .tick_o   (tick[g]),
         .pend_o   (cfg_pend[g])
      );
   end

endmodule
